if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline. It owns the PC register, drives the instruction-memory request with wait-state support, and presents PCOUT/IR to the IF/ID latch each cycle. It applies branch/jump redirects from EX, honours load-use stalls, and discards wrong-path responses when a redirect lands during an outstanding wait-stated fetch.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_next_pc.sv | 57 +++++
 rtl/if_fetch_unit.sv | 75 +++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions used by the fetch stage and the IF/ID and ID
// stages.
// Contents:
//   XLEN          - datapath width
//   RESET_PC      - PC value loaded on reset
//   NOP_INSN      - canonical bubble instruction (addi x0,x0,0)
//   fetch_state_e - fetch FSM state encoding
//   word_align    - clears the two low address bits
package if_fetch_unit_pkg;

  localparam int unsigned       XLEN     = 32;
  localparam logic [XLEN-1:0]   RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0]   NOP_INSN = 32'h0000_0013;

  // FETCH: the outstanding response belongs to the current path.
  // KILL : a redirect arrived during a wait; the outstanding response is stale.
  typedef enum logic {
    FETCH = 1'b0,
    KILL  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_next_pc.sv
// Combinational next-PC / next-state select for the fetch stage.
// Ports:
//   pc_i, pend_pc_i, state_i - current register values
//   redirect_i, redirect_pc_i - EX-resolved branch/jump (target gets word-aligned)
//   ready_i                  - instruction memory response this cycle
//   stall_i                  - load-use stall from the hazard unit
//   pc_d_o, pend_pc_d_o, state_d_o - next values (the top applies the enable)
// Priority: redirect > stall > sequential increment.
module if_fetch_unit_next_pc
  import if_fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pend_pc_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  fetch_state_e    state_i,
  input  logic            ready_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pend_pc_d_o,
  output fetch_state_e    state_d_o
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_inc;

  assign target = word_align(redirect_pc_i);
  assign pc_inc = pc_i + 32'd4;  // wraps modulo 2^32

  always_comb begin
    pc_d_o      = pc_i;
    pend_pc_d_o = pend_pc_i;
    state_d_o   = state_i;
    if (state_i == FETCH) begin
      if (ready_i) begin
        if (redirect_i) begin
          pc_d_o = target;
        end else if (!stall_i) begin
          pc_d_o = pc_inc;
        end
      end else if (redirect_i) begin
        // Address must stay stable during the wait, so park the target.
        pend_pc_d_o = target;
        state_d_o   = KILL;
      end
    end else begin
      if (ready_i) begin
        // Stale response returns; a same-cycle redirect is newer than pend_pc.
        pc_d_o    = redirect_i ? target : pend_pc_i;
        state_d_o = FETCH;
      end else if (redirect_i) begin
        pend_pc_d_o = target;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests
// with wait-state support, and presents PCOUT/IR to the IF/ID latch.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - pipeline enable; low freezes pc/state/pend_pc
//   stall           - load-use stall (pc holds, same address re-fetched)
//   redirect, redirect_pc - taken branch/jump from EX
//   imem_req/imem_addr    - fetch request, word-aligned address
//   imem_ready/imem_rdata - memory response
//   PCOUT, IR, if_valid   - instruction to IF/ID (NOP_INSN when invalid)
//   fetch_busy      - request outstanding without response this cycle
//   state_o         - fetch FSM state, for observation
// Memory handshake: a request is held (imem_req=1, imem_addr stable) until a
// cycle with imem_ready=1; that cycle's imem_rdata is the response, consumed
// combinationally and the PC advances on the following posedge.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCOUT,
  output logic [XLEN-1:0] IR,
  output logic            if_valid,
  output logic            fetch_busy,
  output fetch_state_e    state_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  fetch_state_e    state_q, state_d;

  if_fetch_unit_next_pc u_next_pc (
    .pc_i          (pc_q),
    .pend_pc_i     (pend_pc_q),
    .redirect_pc_i (redirect_pc),
    .state_i       (state_q),
    .ready_i       (imem_ready),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .pc_d_o        (pc_d),
    .pend_pc_d_o   (pend_pc_d),
    .state_d_o     (state_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
      state_q   <= FETCH;
    end else if (en) begin
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      state_q   <= state_d;
    end
  end

  // Request drops during reset so any in-flight response is ignored.
  assign imem_req   = ~rst;
  assign imem_addr  = pc_q;
  assign PCOUT      = pc_q;
  // A response is in-path only in FETCH and only if EX is not redirecting away.
  assign if_valid   = ~rst & (state_q == FETCH) & imem_ready & ~redirect;
  assign IR         = if_valid ? imem_rdata : NOP_INSN;
  assign fetch_busy = imem_req & ~imem_ready;
  assign state_o    = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst, en, stall, redirect, imem_ready;
  logic [31:0]  redirect_pc, imem_rdata;
  logic         imem_req, if_valid, fetch_busy;
  logic [31:0]  imem_addr, PCOUT, IR;
  fetch_state_e state_o;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PCOUT(PCOUT), .IR(IR),
    .if_valid(if_valid), .fetch_busy(fetch_busy), .state_o(state_o)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // m_pc: address being fetched; m_kill: the outstanding response is stale;
  // m_pend: latest redirect target seen while the memory was busy.
  logic [31:0] m_pc, m_pend;
  logic        m_kill;
  logic [99:0] obs_vec, exp_vec;

  task automatic model_reset();
    m_pc = RESET_PC; m_pend = '0; m_kill = 1'b0;
  endtask

  // Drive inputs, wait to mid-cycle, capture observed and expected outputs.
  task automatic drive(input logic e, input logic s, input logic r,
                       input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] rd);
    logic ev;
    en = e; stall = s; redirect = r; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rd;
    @(negedge clk);
    ev = !m_kill && rdy && !r;
    obs_vec = {imem_req, imem_addr, PCOUT, IR, if_valid, fetch_busy, state_o == KILL};
    exp_vec = {1'b1, m_pc, m_pc, ev ? rd : NOP_INSN, ev, ~rdy, m_kill};
  endtask

  // Apply the clock edge to the model using the inputs held across it.
  task automatic advance();
    logic [31:0] tgt;
    @(posedge clk);
    tgt = redirect_pc & ~32'h3;
    if (en) begin
      if (!imem_ready) begin
        if (redirect) begin m_pend = tgt; m_kill = 1'b1; end
      end else if (m_kill || redirect) begin
        m_pc = redirect ? tgt : m_pend;
        m_kill = 1'b0;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #12;
    total++;
    if ({imem_req, IR, PCOUT, if_valid, fetch_busy, state_o == KILL} !==
        {1'b0, NOP_INSN, RESET_PC, 3'b000}) begin
      bad++;
      $display("FAIL reset req=%b IR=%h PCOUT=%h v=%b busy=%b st=%0d", imem_req, IR,
               PCOUT, if_valid, fetch_busy, state_o);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, $urandom);
      total++;
      if (obs_vec !== exp_vec) begin bad++; $display("FAIL zero_wait obs=%h exp=%h", obs_vec, exp_vec); end
      total++;
      if ({imem_addr, if_valid} !== {i * 4, 1'b1}) begin
        bad++; $display("FAIL zero_wait_addr got=%h v=%b want=%h", imem_addr, if_valid, i * 4);
      end
      advance();
    end
  endtask

  task automatic test_wait_states();
    drive(1, 0, 1, 32'h8, 1, $urandom); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, $urandom);
      total++;
      if ({imem_addr, IR, if_valid, fetch_busy} !== {32'h8, NOP_INSN, 2'b01}) begin
        bad++; $display("FAIL wait_bubble addr=%h IR=%h v=%b busy=%b", imem_addr, IR, if_valid, fetch_busy);
      end
      advance();
    end
    drive(1, 0, 0, 0, 1, 32'h1234_5678);
    total++;
    if ({IR, if_valid} !== {32'h1234_5678, 1'b1}) begin
      bad++; $display("FAIL wait_resp IR=%h v=%b want 12345678/1", IR, if_valid);
    end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'hC) begin bad++; $display("FAIL wait_next addr=%h want 0000000c", imem_addr); end
    advance();
  endtask

  task automatic test_stall();
    drive(1, 0, 1, 32'h10, 1, $urandom); advance();
    drive(1, 1, 0, 0, 1, $urandom);
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL stall obs=%h exp=%h", obs_vec, exp_vec); end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'h10) begin bad++; $display("FAIL stall_refetch addr=%h want 00000010", imem_addr); end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'h14) begin bad++; $display("FAIL stall_next addr=%h want 00000014", imem_addr); end
    advance();
  endtask

  task automatic test_redirect();
    drive(1, 0, 1, 32'h20, 1, $urandom); advance();
    drive(1, 0, 1, 32'h103, 1, $urandom);
    total++;
    if ({IR, if_valid} !== {NOP_INSN, 1'b0}) begin
      bad++; $display("FAIL redirect_squash IR=%h v=%b", IR, if_valid);
    end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'h100) begin bad++; $display("FAIL redirect_target addr=%h want 00000100", imem_addr); end
    advance();
  endtask

  task automatic test_kill();
    drive(1, 0, 1, 32'h30, 1, $urandom); advance();
    drive(1, 0, 1, 32'h200, 0, $urandom); advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, $urandom);
      total++;
      if ({state_o == KILL, imem_addr} !== {1'b1, 32'h30}) begin
        bad++; $display("FAIL kill_wait st=%0d addr=%h", state_o, imem_addr);
      end
      advance();
    end
    drive(1, 0, 0, 0, 1, 32'hABCD_0001);
    total++;
    if ({IR, if_valid} !== {NOP_INSN, 1'b0}) begin
      bad++; $display("FAIL kill_drop IR=%h v=%b", IR, if_valid);
    end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if ({imem_addr, state_o == KILL} !== {32'h200, 1'b0}) begin
      bad++; $display("FAIL kill_target addr=%h st=%0d want 00000200/FETCH", imem_addr, state_o);
    end
    advance();
  endtask

  task automatic test_en_low();
    logic [31:0] held;
    held = m_pc;
    drive(0, 0, 1, 32'h400, 1, $urandom); advance();
    drive(0, 0, 0, 0, 1, $urandom); advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== held) begin bad++; $display("FAIL en_low addr=%h want %h", imem_addr, held); end
    advance();
  endtask

  task automatic test_wrap();
    drive(1, 0, 1, 32'hFFFF_FFFF, 1, $urandom); advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top addr=%h want fffffffc", imem_addr); end
    advance();
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero addr=%h want 00000000", imem_addr); end
    advance();
  endtask

  task automatic test_rst_mid_wait();
    drive(1, 0, 1, 32'h40, 1, $urandom); advance();
    drive(1, 0, 1, 32'h300, 0, $urandom); advance();
    drive(1, 0, 0, 0, 0, $urandom);
    total++;
    if (obs_vec !== exp_vec) begin bad++; $display("FAIL pre_rst obs=%h exp=%h", obs_vec, exp_vec); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({imem_req, PCOUT, fetch_busy, if_valid, state_o == KILL} !== {1'b0, RESET_PC, 3'b000}) begin
      bad++; $display("FAIL rst_mid_wait req=%b PCOUT=%h busy=%b v=%b st=%0d", imem_req, PCOUT,
                      fetch_busy, if_valid, state_o);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    drive(1, 0, 0, 0, 1, $urandom);
    total++;
    if (imem_addr !== RESET_PC) begin bad++; $display("FAIL post_rst addr=%h", imem_addr); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
            $urandom, $urandom_range(0, 3) != 0, $urandom);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs_vec, exp_vec);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect();
    test_kill();
    test_en_low();
    test_wrap();
    test_rst_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
